pipe_stage_buf: RTL and testbench

- Parametrised successor to the fixed-field pipeline registers between EX/MEM/WB.
- Carries an opaque packed payload through a DEPTH-entry elastic buffer using a valid/ready handshake, synchronous flush and NOP insertion.
- Has a free-running side channel for multi-cycle unit state (e.g. hilo/cnt of madd/msub) that ignores handshake and flush.
- Lets stages stall independently instead of sharing one global enable.

---
 rtl/pipe_stage_buf.sv | 130 +++++++++++++
 tb/tb_pipe_stage_buf.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline stage: DEPTH-entry valid/ready buffer with flush, plus a free-running side channel.
// Optional performance counters are enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_buf #(
    parameter int                DATA_W    = 256,
    parameter int                DEPTH     = 2,
    parameter logic [DATA_W-1:0] NOP_VALUE = '0,
    parameter int                SIDE_W    = 66
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    input  logic [SIDE_W-1:0]            side_i,
    output logic [SIDE_W-1:0]            side_o,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]                  perf_stall,
    output logic [31:0]                  perf_bubble,
    output logic [31:0]                  perf_flush
`endif
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [SIDE_W-1:0] side_q;
    logic              push;
    logic              pop;

    // Explicit wrap so non-power-of-2 depths stay inside the array.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign out_valid = (count_q != '0);
    assign out_data  = out_valid ? mem_q[rd_ptr_q] : NOP_VALUE;
    assign occupancy = count_q;
    assign side_o    = side_q;

    generate
        if (DEPTH == 1) begin : g_ready_comb
            assign in_ready = ~out_valid | out_ready;
        end else begin : g_ready_reg
            assign in_ready = (count_q < CNT_W'(DEPTH));
        end
    endgenerate

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] = NOP_VALUE;
            end
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = in_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= NOP_VALUE;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            side_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            side_q   <= side_i;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_bubble_q;
    logic [31:0] perf_flush_q;

    // Counters wrap naturally at 32 bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_q  <= '0;
            perf_bubble_q <= '0;
            perf_flush_q  <= '0;
        end else begin
            if (out_valid & ~out_ready) perf_stall_q  <= perf_stall_q + 32'd1;
            if (~out_valid)             perf_bubble_q <= perf_bubble_q + 32'd1;
            if (flush)                  perf_flush_q  <= perf_flush_q + 32'd1;
        end
    end

    assign perf_stall  = perf_stall_q;
    assign perf_bubble = perf_bubble_q;
    assign perf_flush  = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: DEPTH=2, DEPTH=1 and DEPTH=3 instances driven side by side.
module tb_pipe_stage_buf;

    localparam logic [31:0] NOP_A = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // DEPTH=2 instance
    logic        a_flush = 0, a_iv = 0, a_or = 0;
    logic [31:0] a_id = '0;
    logic        a_ir, a_ov;
    logic [31:0] a_od;
    logic [65:0] a_si = '0, a_so;
    logic [1:0]  a_occ;
    // DEPTH=1 instance
    logic        b_flush = 0, b_iv = 0, b_or = 0;
    logic [31:0] b_id = '0;
    logic        b_ir, b_ov;
    logic [31:0] b_od;
    logic [65:0] b_si = '0, b_so;
    logic [0:0]  b_occ;
    // DEPTH=3 instance
    logic        c_flush = 0, c_iv = 0, c_or = 0;
    logic [31:0] c_id = '0;
    logic        c_ir, c_ov;
    logic [31:0] c_od;
    logic [65:0] c_si = '0, c_so;
    logic [1:0]  c_occ;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] a_ps, a_pb, a_pf, b_ps, b_pb, b_pf, c_ps, c_pb, c_pf;
`endif

    pipe_stage_buf #(.DATA_W(32), .DEPTH(2), .NOP_VALUE(NOP_A), .SIDE_W(66)) u_d2 (
        .clk(clk), .rst(rst), .flush(a_flush), .in_valid(a_iv), .in_ready(a_ir),
        .in_data(a_id), .out_valid(a_ov), .out_ready(a_or), .out_data(a_od),
        .side_i(a_si), .side_o(a_so), .occupancy(a_occ)
`ifdef PIPE_STAGE_PERF_EN
        , .perf_stall(a_ps), .perf_bubble(a_pb), .perf_flush(a_pf)
`endif
    );

    pipe_stage_buf #(.DATA_W(32), .DEPTH(1), .NOP_VALUE(32'h0), .SIDE_W(66)) u_d1 (
        .clk(clk), .rst(rst), .flush(b_flush), .in_valid(b_iv), .in_ready(b_ir),
        .in_data(b_id), .out_valid(b_ov), .out_ready(b_or), .out_data(b_od),
        .side_i(b_si), .side_o(b_so), .occupancy(b_occ)
`ifdef PIPE_STAGE_PERF_EN
        , .perf_stall(b_ps), .perf_bubble(b_pb), .perf_flush(b_pf)
`endif
    );

    pipe_stage_buf #(.DATA_W(32), .DEPTH(3), .NOP_VALUE(32'h0), .SIDE_W(66)) u_d3 (
        .clk(clk), .rst(rst), .flush(c_flush), .in_valid(c_iv), .in_ready(c_ir),
        .in_data(c_id), .out_valid(c_ov), .out_ready(c_or), .out_data(c_od),
        .side_i(c_si), .side_o(c_so), .occupancy(c_occ)
`ifdef PIPE_STAGE_PERF_EN
        , .perf_stall(c_ps), .perf_bubble(c_pb), .perf_flush(c_pf)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // DEPTH=3 interleaved table: in_valid, in_data, out_ready, expected occupancy/head after the edge
    int t_iv   [11] = '{1, 1, 1, 1, 1, 1, 0, 1, 1, 0, 0};
    int t_id   [11] = '{1, 2, 3, 4, 4, 5, 0, 6, 7, 0, 0};
    int t_or   [11] = '{0, 0, 0, 1, 1, 0, 1, 1, 1, 1, 1};
    int t_occ  [11] = '{1, 2, 3, 2, 2, 3, 2, 2, 2, 1, 0};
    int t_head [11] = '{1, 1, 1, 2, 3, 3, 4, 5, 6, 7, 0};

    initial begin
`ifdef PIPE_STAGE_PERF_EN
        logic [31:0] s0;
`endif
        a_si = 66'h3_0000_0000_1111_2222;
        #2 rst = 1'b0;
        #1;
        chk("rst_ov", a_ov, 0);
        chk("rst_od", a_od, NOP_A);
        chk("rst_occ", a_occ, 0);
        chk("rst_so", a_so, 0);
        #5 rst = 1'b1;
        #1;
        chk("rst_ir", a_ir, 1);

        // Streaming
        a_or = 1; a_iv = 1; a_id = 32'h11; a_si = 66'h2_AAAA_BBBB_CCCC_DDDD;
        tick();
        chk("str_od0", a_od, 32'h11); chk("str_ov0", a_ov, 1); chk("str_ir0", a_ir, 1);
        chk("side0", a_so, 66'h2_AAAA_BBBB_CCCC_DDDD);
        a_id = 32'h22; a_si = 66'h1_0000_0000_0000_0005;
        tick();
        chk("str_od1", a_od, 32'h22); chk("str_ir1", a_ir, 1);
        chk("side1", a_so, 66'h1_0000_0000_0000_0005);
        a_id = 32'h33;
        tick();
        chk("str_od2", a_od, 32'h33); chk("str_ir2", a_ir, 1);
        a_iv = 0; a_id = 32'hBAD0BAD0;
        tick();
        chk("str_ov_end", a_ov, 0); chk("str_od_end", a_od, NOP_A);

        // Backpressure
        a_or = 0; a_iv = 1; a_id = 32'hA;
        tick();
        chk("bp_od_a", a_od, 32'hA);
`ifdef PIPE_STAGE_PERF_EN
        s0 = a_ps;
`endif
        a_id = 32'hB;
        tick();
        chk("bp_occ_full", a_occ, 2); chk("bp_ir_full", a_ir, 0); chk("bp_od_hold", a_od, 32'hA);
        a_id = 32'hC;
        tick();
        chk("bp_occ_rej", a_occ, 2); chk("bp_od_rej", a_od, 32'hA);
        a_iv = 0;
        tick();
        tick();
        chk("bp_ov_stable", a_ov, 1); chk("bp_od_stable", a_od, 32'hA);
`ifdef PIPE_STAGE_PERF_EN
        chk("perf_stall4", a_ps - s0, 4);
`endif
        a_or = 1; a_iv = 1; a_id = 32'hC;
        tick();
        chk("bp_od_b", a_od, 32'hB); chk("bp_occ_b", a_occ, 1);
        tick();
        chk("bp_od_c", a_od, 32'hC); chk("bp_occ_c", a_occ, 1);
        a_iv = 0;
        tick();
        chk("bp_ov_end", a_ov, 0);

        // Flush collision
        a_or = 0; a_iv = 1; a_id = 32'h44;
        tick();
        chk("fl_occ_pre", a_occ, 1);
        a_flush = 1; a_id = 32'h55; a_or = 1; a_si = 66'h3_1234_5678_9ABC_DEF0;
        #1;
        chk("fl_ir", a_ir, 1);
        tick();
        chk("fl_occ", a_occ, 0); chk("fl_ov", a_ov, 0); chk("fl_od", a_od, NOP_A);
        chk("fl_side", a_so, 66'h3_1234_5678_9ABC_DEF0);
        a_flush = 0; a_iv = 0;
        tick();
        chk("fl_ov_after", a_ov, 0); chk("fl_od_after", a_od, NOP_A);

        // Reset mid-operation with two entries held
        a_or = 0; a_iv = 1; a_id = 32'h66;
        tick();
        a_id = 32'h77;
        tick();
        chk("mr_occ_pre", a_occ, 2);
        a_iv = 0;
        #2 rst = 1'b0;
        #1;
        chk("mr_ov", a_ov, 0); chk("mr_od", a_od, NOP_A); chk("mr_occ", a_occ, 0); chk("mr_so", a_so, 0);
        rst = 1'b1;
        #1;
        chk("mr_ir", a_ir, 1);
        tick();
        chk("mr_ov_after", a_ov, 0);

        // DEPTH=1
        b_or = 0; b_iv = 1; b_id = 32'h1;
        tick();
        chk("d1_od1", b_od, 32'h1); chk("d1_occ1", b_occ, 1);
        b_id = 32'h9;
        #1;
        chk("d1_ir_full", b_ir, 0);
        tick();
        chk("d1_od_rej", b_od, 32'h1);
        b_or = 1; b_id = 32'h2;
        #1;
        chk("d1_ir_comb", b_ir, 1);
        tick();
        chk("d1_od2", b_od, 32'h2); chk("d1_ov2", b_ov, 1);
        b_id = 32'h3;
        tick();
        chk("d1_od3", b_od, 32'h3); chk("d1_ov3", b_ov, 1);
        b_iv = 0;
        tick();
        chk("d1_ov_end", b_ov, 0); chk("d1_od_end", b_od, 0);

        // DEPTH=3 pointer wrap
        for (int i = 0; i < 11; i++) begin
            c_iv = t_iv[i][0];
            c_id = t_id[i];
            c_or = t_or[i][0];
            tick();
            chk($sformatf("d3_occ%0d", i), c_occ, t_occ[i]);
            chk($sformatf("d3_head%0d", i), c_od, t_head[i]);
        end
        c_iv = 0; c_or = 0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
